// File: rtl/bs_pkg.sv
// Shared constants for the Black-Scholes host controller: core command and status codes,
// the slave-port register map and the sequencer state encoding.
package bs_pkg;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_RUN  = 4'd1;
  localparam logic [3:0] CMD_ACK  = 4'd2;

  localparam logic [3:0] CORE_IDLE     = 4'd0;
  localparam logic [3:0] CORE_RUNNING  = 4'd1;
  localparam logic [3:0] CORE_COMPLETE = 4'd2;

  localparam logic [3:0] A_CTRL    = 4'd0;
  localparam logic [3:0] A_STAT    = 4'd1;
  localparam logic [3:0] A_NITER   = 4'd2;
  localparam logic [3:0] A_CONSTK  = 4'd3;
  localparam logic [3:0] A_CONST1  = 4'd4;
  localparam logic [3:0] A_CONST2  = 4'd5;
  localparam logic [3:0] A_CONST3  = 4'd6;
  localparam logic [3:0] A_ACC     = 4'd7;
  localparam logic [3:0] A_POW_ACC = 4'd8;
  localparam logic [3:0] A_CYCLES  = 4'd9;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT_CMPL = 3'd2;
  localparam logic [2:0] S_ACK_REQ   = 3'd3;
  localparam logic [2:0] S_FIN       = 3'd4;

  function automatic logic [31:0] stat_word(input logic busy, input logic done,
                                            input logic timeout, input logic [3:0] core_status);
    return {24'd0, core_status, 1'b0, timeout, done, busy};
  endfunction

endpackage

// File: rtl/bs_host_regs.sv
// Slave-port decode for the host controller: run constants, IRQ enable, control/W1C
// strobes and the registered read mux.
module bs_host_regs
  import bs_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic [3:0]  addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        busy,
  input  logic        done,
  input  logic        timeout,
  input  logic [3:0]  core_status,
  input  logic [31:0] acc,
  input  logic [31:0] pow_acc,
  input  logic [31:0] cycles,
  output logic [31:0] rdata,
  output logic [31:0] niter,
  output logic [31:0] constK,
  output logic [31:0] const1,
  output logic [31:0] const2,
  output logic [31:0] const3,
  output logic        irq_en,
  output logic        start,
  output logic        clr_done,
  output logic        clr_timeout
);

  logic [31:0] niter_q, niter_d, constk_q, constk_d;
  logic [31:0] const1_q, const1_d, const2_q, const2_d, const3_q, const3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_en_q, irq_en_d;

  always_comb begin
    niter_d  = niter_q;
    constk_d = constk_q;
    const1_d = const1_q;
    const2_d = const2_q;
    const3_d = const3_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;
    if (wr && addr == A_CTRL) irq_en_d = wdata[1];
    // Constants are frozen for the whole run so the core never sees them change.
    if (wr && !busy) begin
      case (addr)
        A_NITER:  niter_d  = wdata;
        A_CONSTK: constk_d = wdata;
        A_CONST1: const1_d = wdata;
        A_CONST2: const2_d = wdata;
        A_CONST3: const3_d = wdata;
        default: ;
      endcase
    end
    if (rd) begin
      case (addr)
        A_STAT:    rdata_d = stat_word(busy, done, timeout, core_status);
        A_NITER:   rdata_d = niter_q;
        A_CONSTK:  rdata_d = constk_q;
        A_CONST1:  rdata_d = const1_q;
        A_CONST2:  rdata_d = const2_q;
        A_CONST3:  rdata_d = const3_q;
        A_ACC:     rdata_d = acc;
        A_POW_ACC: rdata_d = pow_acc;
        A_CYCLES:  rdata_d = cycles;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      niter_q  <= '0;
      constk_q <= '0;
      const1_q <= '0;
      const2_q <= '0;
      const3_q <= '0;
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      niter_q  <= niter_d;
      constk_q <= constk_d;
      const1_q <= const1_d;
      const2_q <= const2_d;
      const3_q <= const3_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
    end
  end

  assign start       = wr && addr == A_CTRL && wdata[0];
  assign clr_done    = wr && addr == A_STAT && wdata[1];
  assign clr_timeout = wr && addr == A_STAT && wdata[2];
  assign rdata  = rdata_q;
  assign niter  = niter_q;
  assign constK = constk_q;
  assign const1 = const1_q;
  assign const2 = const2_q;
  assign const3 = const3_q;
  assign irq_en = irq_en_q;

endmodule

// File: rtl/bs_host_ctrl.sv
// Host-side sequencer for the Black-Scholes core: RUN, wait COMPLETE, capture results,
// ACK, wait IDLE, with a per-state timeout and a sticky done flag / level interrupt.
module bs_host_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter logic [3:0]  CMD_RUN        = 4'd1,
  parameter logic [3:0]  CMD_ACK        = 4'd2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [3:0]  addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [31:0] niter,
  output logic [31:0] constK,
  output logic [31:0] const1,
  output logic [31:0] const2,
  output logic [31:0] const3,
  output logic [3:0]  cmd,
  input  logic [3:0]  core_status,
  input  logic [31:0] core_acc,
  input  logic [31:0] core_pow_acc
);
  import bs_pkg::*;

  logic [2:0]  state_q, state_d;
  logic [31:0] wait_q, wait_d, cycles_q, cycles_d;
  logic [31:0] acc_q, acc_d, pow_acc_q, pow_acc_d;
  logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        irq_en, start, clr_done, clr_timeout;
  logic        wait_expired, abort;

  bs_host_regs u_regs (
    .clk         (clk),
    .nreset      (nreset),
    .addr        (addr),
    .wr          (wr),
    .wdata       (wdata),
    .rd          (rd),
    .busy        (busy_q),
    .done        (done_q),
    .timeout     (timeout_q),
    .core_status (core_status),
    .acc         (acc_q),
    .pow_acc     (pow_acc_q),
    .cycles      (cycles_q),
    .rdata       (rdata),
    .niter       (niter),
    .constK      (constK),
    .const1      (const1),
    .const2      (const2),
    .const3      (const3),
    .irq_en      (irq_en),
    .start       (start),
    .clr_done    (clr_done),
    .clr_timeout (clr_timeout)
  );

  assign wait_expired = (wait_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    acc_d     = acc_q;
    pow_acc_d = pow_acc_q;
    done_d    = done_q & ~clr_done;
    timeout_d = timeout_q & ~clr_timeout;
    abort     = 1'b0;
    // Illegal core codes simply fail to match and fall through to the timeout.
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_RUN_REQ;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        cycles_d  = '0;
      end
      S_RUN_REQ: begin
        cycles_d = cycles_q + 32'd1;
        if (core_status == CORE_RUNNING) state_d = S_WAIT_CMPL;
        else                             abort   = wait_expired;
      end
      S_WAIT_CMPL: begin
        if (core_status == CORE_COMPLETE) begin
          acc_d     = core_acc;
          pow_acc_d = core_pow_acc;
          state_d   = S_ACK_REQ;
        end else begin
          cycles_d = cycles_q + 32'd1;
          abort    = wait_expired;
        end
      end
      S_ACK_REQ: begin
        if (core_status == CORE_IDLE) state_d = S_FIN;
        else                          abort   = wait_expired;
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      timeout_d = 1'b1;
      state_d   = S_IDLE;
    end
    wait_d = (state_d != state_q || state_q == S_IDLE) ? '0 : wait_q + 32'd1;
    busy_d = (state_d != S_IDLE);
    // cmd follows the next state so it is registered and never carries RUN and ACK together.
    case (state_d)
      S_RUN_REQ: cmd_d = CMD_RUN;
      S_ACK_REQ: cmd_d = CMD_ACK;
      default:   cmd_d = CMD_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cycles_q  <= '0;
      acc_q     <= '0;
      pow_acc_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cmd_q     <= CMD_NONE;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cycles_q  <= cycles_d;
      acc_q     <= acc_d;
      pow_acc_q <= pow_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cmd_q     <= cmd_d;
    end
  end

  assign cmd = cmd_q;
  assign irq = done_q & irq_en;

endmodule

// File: tb/tb_bs_host_ctrl.sv
// Bench for bs_host_ctrl: a long-run instance and a short-timeout instance share the bus,
// each driven by a small behavioural core; reads are checked through an expectation queue.
module tb_bs_host_ctrl;
  import bs_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  addr = '0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata [2];
  logic        irq [2];
  logic [31:0] niter [2], constk [2], c1 [2], c2 [2], c3 [2];
  logic [3:0]  cmd [2];
  logic [3:0]  cst [2];
  logic [31:0] ccnt [2];
  logic [31:0] cacc [2], cpow [2];
  logic        stuck1 = 1'b0;

  bs_host_ctrl dut (
    .clk(clk), .nreset(nreset), .addr(addr), .wr(wr), .wdata(wdata), .rd(rd),
    .rdata(rdata[0]), .irq(irq[0]), .niter(niter[0]), .constK(constk[0]),
    .const1(c1[0]), .const2(c2[0]), .const3(c3[0]), .cmd(cmd[0]),
    .core_status(cst[0]), .core_acc(cacc[0]), .core_pow_acc(cpow[0]));

  bs_host_ctrl #(.TIMEOUT_CYCLES(32'd64)) dut_to (
    .clk(clk), .nreset(nreset), .addr(addr), .wr(wr), .wdata(wdata), .rd(rd),
    .rdata(rdata[1]), .irq(irq[1]), .niter(niter[1]), .constK(constk[1]),
    .const1(c1[1]), .const2(c2[1]), .const3(c3[1]), .cmd(cmd[1]),
    .core_status(cst[1]), .core_acc(cacc[1]), .core_pow_acc(cpow[1]));

  // Behavioural cores: RUNNING one cycle after RUN, COMPLETE run_len cycles later.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 2; i++) begin
        cst[i]  <= CORE_IDLE;
        ccnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (cst[i])
          CORE_IDLE: if (cmd[i] == 4'd1) begin
            cst[i]  <= CORE_RUNNING;
            ccnt[i] <= '0;
          end
          CORE_RUNNING: begin
            ccnt[i] <= ccnt[i] + 32'd1;
            if (!(i == 1 && stuck1) && ccnt[i] == ((i == 0) ? 32'd159 : 32'd9))
              cst[i] <= CORE_COMPLETE;
          end
          CORE_COMPLETE: if (cmd[i] == 4'd2) cst[i] <= CORE_IDLE;
          default: cst[i] <= CORE_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cacc[i] = 32'hBAD0_0000 | ccnt[i];
      cpow[i] = 32'hBAD1_0000 | ccnt[i];
      if (cst[i] == CORE_COMPLETE) begin
        cacc[i] = (i == 0) ? 32'h3F80_0000 : 32'h1111_1111;
        cpow[i] = (i == 0) ? 32'h4000_0000 : 32'h2222_2222;
      end
    end
  end

  logic [3:0] cmd_hist [$];
  logic [3:0] cmd0_prev = 4'd0;
  always @(negedge clk) begin
    if (cmd[0] != cmd0_prev) cmd_hist.push_back(cmd[0]);
    cmd0_prev <= cmd[0];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [31:0] exp;
    string       nm;
  } rd_exp_t;
  rd_exp_t sb [$];

  typedef struct {
    logic [3:0]  a;
    logic        we;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic sb_pop();
    rd_exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: read data with no expectation queued");
    end else begin
      e = sb.pop_front();
      chk(e.nm, rdata[e.inst], e.exp);
    end
  endtask

  task automatic rd1(input int inst, input logic [3:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    rd = 1'b1; addr = a;
    sb.push_back('{inst, exp, nm});
    @(negedge clk);
    rd = 1'b0;
    sb_pop();
  endtask

  task automatic rd2(input int inst, input logic [3:0] a1, input logic [31:0] e1,
                     input logic [3:0] a2, input logic [31:0] e2, input string nm);
    @(negedge clk);
    rd = 1'b1; addr = a1;
    sb.push_back('{inst, e1, {nm, "_a"}});
    @(negedge clk);
    addr = a2;
    sb.push_back('{inst, e2, {nm, "_b"}});
    sb_pop();
    @(negedge clk);
    rd = 1'b0;
    sb_pop();
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_irq0(input string nm, input int bound);
    int k = 0;
    while (!irq[0] && k < bound) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!irq[0]) begin
      errors++;
      $display("FAIL %s: irq still 0 after %0d cycles, required 1", nm, bound);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    logic [31:0] cyc;
    logic [3:0] prev;
    logic [3:0] seq [4];
    bit found;

    tbl[0] = '{A_NITER,   1'b1, 32'd100,       32'd100};
    tbl[1] = '{A_CONSTK,  1'b1, 32'h42C8_0000, 32'h42C8_0000};
    tbl[2] = '{A_CONST1,  1'b1, 32'h3F00_0000, 32'h3F00_0000};
    tbl[3] = '{A_CONST2,  1'b1, 32'h4040_0000, 32'h4040_0000};
    tbl[4] = '{A_CONST3,  1'b1, 32'h1234_5678, 32'h1234_5678};
    tbl[5] = '{4'hF,      1'b1, 32'hDEAD_BEEF, 32'h0};
    tbl[6] = '{A_ACC,     1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[7] = '{A_CTRL,    1'b0, 32'h0,         32'h0};
    tbl[8] = '{A_CYCLES,  1'b0, 32'h0,         32'h0};
    tbl[9] = '{A_STAT,    1'b0, 32'h0,         32'h0};

    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_cmd", {28'd0, cmd[0]}, 32'h0);
    chk("rst_irq", {31'd0, irq[0]}, 32'h0);
    chk("rst_niter", niter[0], 32'h0);
    nreset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) wr1(tbl[i].a, tbl[i].d);
      rd1(0, tbl[i].a, tbl[i].exp, $sformatf("tbl%0d_addr%0d", i, tbl[i].a));
    end
    chk("out_niter", niter[0], 32'd100);
    chk("out_constk", constk[0], 32'h42C8_0000);
    chk("out_const3", c3[0], 32'h1234_5678);

    // Main run with IRQ enabled.
    h0 = cmd_hist.size();
    wr1(A_CTRL, 32'h3);
    repeat (20) @(negedge clk);
    rd1(0, A_STAT, 32'h11, "stat_busy");
    wr1(A_NITER, 32'd5);
    chk("niter_hold_busy", niter[0], 32'd100);
    wr1(A_CTRL, 32'h3);
    wait_irq0("irq_run1", 400);
    rd1(0, A_STAT, 32'h02, "stat_done");
    rd2(0, A_ACC, 32'h3F80_0000, A_POW_ACC, 32'h4000_0000, "results");
    @(negedge clk); rd = 1'b1; addr = A_CYCLES;
    @(negedge clk); rd = 1'b0; cyc = rdata[0];
    checks++;
    if (cyc < 32'd160 || cyc > 32'd162) begin
      errors++;
      $display("FAIL cycles_count: got %0d expected 160..162", cyc);
    end
    seq = '{4'd1, 4'd0, 4'd2, 4'd0};
    chk("cmd_seq_len", cmd_hist.size() - h0, 32'd4);
    for (int j = 0; j < 4; j++)
      if (h0 + j < cmd_hist.size())
        chk($sformatf("cmd_seq%0d", j), {28'd0, cmd_hist[h0 + j]}, {28'd0, seq[j]});
    wr1(A_STAT, 32'h2);
    chk("irq_fall_w1c", {31'd0, irq[0]}, 32'h0);

    // Read and write to the same register in one cycle: read sees the old value.
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; addr = A_NITER; wdata = 32'd7;
    sb.push_back('{0, 32'd100, "rw_same_cycle"});
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    sb_pop();
    rd1(0, A_NITER, 32'd7, "niter_after_rw");
    chk("out_niter_rw", niter[0], 32'd7);
    rd1(1, A_ACC, 32'h1111_1111, "to_acc_before");

    // Timeout on the short-timeout instance with its core stuck RUNNING.
    stuck1 = 1'b1;
    wr1(A_CTRL, 32'h1);
    repeat (50) @(negedge clk);
    rd1(1, A_STAT, 32'h11, "to_still_busy");
    repeat (20) @(negedge clk);
    rd1(1, A_STAT, 32'h14, "to_flag");
    chk("to_cmd", {28'd0, cmd[1]}, 32'h0);
    rd1(1, A_ACC, 32'h1111_1111, "to_acc_keep");

    // W1C of done landing on the same edge that FIN sets it.
    prev = cmd[0];
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (prev == 4'd2 && cmd[0] == 4'd0) found = 1'b1;
      prev = cmd[0];
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fin_wait: ACK->0 transition not seen, required within 400 cycles");
    end
    wr = 1'b1; addr = A_STAT; wdata = 32'h2;
    @(negedge clk);
    wr = 1'b0;
    rd1(0, A_STAT, 32'h02, "w1c_vs_set");
    wr1(A_STAT, 32'h4);
    rd1(1, A_STAT, 32'h10, "to_w1c");

    // Asynchronous reset in the middle of WAIT_CMPL.
    wr1(A_CTRL, 32'h3);
    repeat (30) @(negedge clk);
    rd1(0, A_STAT, 32'h11, "pre_rst_busy");
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("mid_rst_niter", niter[0], 32'h0);
    chk("mid_rst_constk", constk[0], 32'h0);
    chk("mid_rst_rdata", rdata[0], 32'h0);
    chk("mid_rst_cmd", {28'd0, cmd[0]}, 32'h0);
    chk("mid_rst_irq", {31'd0, irq[0]}, 32'h0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    rd1(0, A_STAT, 32'h0, "post_rst_stat");
    wr1(A_NITER, 32'd100);
    wr1(A_CTRL, 32'h3);
    wait_irq0("irq_after_rst", 400);
    rd1(0, A_STAT, 32'h02, "post_rst_done");
    rd1(0, A_ACC, 32'h3F80_0000, "post_rst_acc");

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
